// File: rtl/comparator_pkg.sv
// Shared definitions for comparator latch controllers: sequencer state
// encoding and the rule that decides whether a latch decision is usable.
package comparator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_EVAL  = 3'd2,
      ST_CHECK = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

   // A strong-ARM latch has resolved only when exactly one rail is high;
   // both-low (not yet resolved) and both-high (precharge/metastable) are rejected.
   function automatic logic pair_valid(input logic p, input logic n);
      return p ^ n;
   endfunction

endpackage

// File: rtl/comparator_sync2.sv
// Width-parameterised two-flop synchroniser for asynchronous latch rails.
module comparator_sync2 #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // Two register stages give a metastable first stage a full cycle to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         // NOTE: non-blocking assignments keep both stages sampling the
         // pre-edge values; blocking here would collapse them into one flop.
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/comparator_seq.sv
// Sequencer for a bank of strong-ARM comparator latches: fires the latch
// clocks, retries channels whose decision was not valid, and majority-votes
// N_VOTE valid decisions per channel into RESULT.
module comparator_seq
   import comparator_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int N_VOTE    = 3,
   parameter int RESET_CYC = 1,
   parameter int EVAL_CYC  = 2,
   parameter int MAX_RETRY = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   input  logic [N_CH-1:0] CH_EN,
   output logic [N_CH-1:0] COMP_CLK,
   input  logic [N_CH-1:0] Outp,
   input  logic [N_CH-1:0] Outn,
   output logic            BUSY,
   output logic            DONE,
   output logic [N_CH-1:0] RESULT,
   output logic [N_CH-1:0] ERR
);

   localparam int VW     = $clog2(N_VOTE + 1);
   localparam int RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   // Evaluate phase is stretched by two cycles so the synchroniser output
   // reflects the latch decision before it is captured.
   localparam int EVAL_LEN = EVAL_CYC + 2;
   localparam int PH_MAX   = (RESET_CYC > EVAL_LEN) ? RESET_CYC : EVAL_LEN;
   localparam int PW       = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   localparam logic [PW-1:0] PRE_LAST   = PW'(RESET_CYC - 1);
   localparam logic [PW-1:0] EVAL_LAST  = PW'(EVAL_LEN - 1);
   localparam logic [VW-1:0] LAST_ROUND = VW'(N_VOTE - 1);
   localparam logic [RW-1:0] RETRY_LIM  = RW'(MAX_RETRY);

   state_t          state;
   logic [PW-1:0]   ph_cnt;
   logic [RW-1:0]   retry;
   logic [VW-1:0]   round_cnt;
   logic [N_CH-1:0] en_q;
   logic [N_CH-1:0] samp_p;
   logic [N_CH-1:0] samp_n;
   logic [N_CH-1:0] rnd_done;
   logic [N_CH-1:0] err_acc;
   logic [VW-1:0]   votes        [N_CH];
   logic [VW-1:0]   valid_rounds [N_CH];

   logic [2*N_CH-1:0] sync_q;
   logic [N_CH-1:0]   pair_ok;
   logic [N_CH-1:0]   rec;
   logic [N_CH-1:0]   pend_left;
   logic [N_CH-1:0]   res_nxt;
   logic [VW-1:0]     votes_nxt [N_CH];
   logic [VW-1:0]     valid_nxt [N_CH];
   logic              retry_again;

   comparator_sync2 #(.W(2 * N_CH)) u_sync (
      .clk (CLK),
      .rst (RST),
      .d   ({Outn, Outp}),
      .q   (sync_q)
   );

   // Evaluate the captured decisions: who records this attempt, who is still pending.
   always_comb begin
      // NOTE: every output of this block is assigned on every pass, so no
      // latch can be inferred.
      rec         = '0;
      pend_left   = '0;
      res_nxt     = '0;
      retry_again = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         pair_ok[i]   = pair_valid(samp_p[i], samp_n[i]);
         rec[i]       = en_q[i] & ~rnd_done[i] & pair_ok[i];
         pend_left[i] = en_q[i] & ~rnd_done[i] & ~pair_ok[i];
         votes_nxt[i] = votes[i] + VW'(rec[i] & samp_p[i]);
         valid_nxt[i] = valid_rounds[i] + VW'(rec[i]);
         res_nxt[i]   = en_q[i] & ({votes_nxt[i], 1'b0} > {1'b0, valid_nxt[i]});
      end
      retry_again = (|pend_left) && (retry < RETRY_LIM);
   end

   // Conversion FSM with registered outputs and all vote/retry/round counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         ph_cnt    <= '0;
         retry     <= '0;
         round_cnt <= '0;
         en_q      <= '0;
         samp_p    <= '0;
         samp_n    <= '0;
         rnd_done  <= '0;
         err_acc   <= '0;
         COMP_CLK  <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         RESULT    <= '0;
         ERR       <= '0;
         // NOTE: the accumulator arrays are a handful of flops, not a RAM,
         // so they take the async reset like every other register.
         for (int i = 0; i < N_CH; i++) begin
            votes[i]        <= '0;
            valid_rounds[i] <= '0;
         end
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (START) begin
                  en_q      <= CH_EN;
                  rnd_done  <= '0;
                  err_acc   <= '0;
                  retry     <= '0;
                  round_cnt <= '0;
                  ph_cnt    <= '0;
                  BUSY      <= 1'b1;
                  for (int i = 0; i < N_CH; i++) begin
                     votes[i]        <= '0;
                     valid_rounds[i] <= '0;
                  end
                  if (CH_EN == '0) begin
                     state  <= ST_FIN;
                     DONE   <= 1'b1;
                     RESULT <= '0;
                     ERR    <= '0;
                  end else begin
                     state <= ST_PRE;
                  end
               end
            end

            ST_PRE: begin
               if (ph_cnt == PRE_LAST) begin
                  ph_cnt   <= '0;
                  COMP_CLK <= en_q;
                  state    <= ST_EVAL;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end

            ST_EVAL: begin
               if (ph_cnt == EVAL_LAST) begin
                  ph_cnt   <= '0;
                  samp_p   <= sync_q[N_CH-1:0];
                  samp_n   <= sync_q[2*N_CH-1:N_CH];
                  COMP_CLK <= '0;
                  state    <= ST_CHECK;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end

            ST_CHECK: begin
               for (int i = 0; i < N_CH; i++) begin
                  votes[i]        <= votes_nxt[i];
                  valid_rounds[i] <= valid_nxt[i];
               end
               if (retry_again) begin
                  retry    <= retry + 1'b1;
                  rnd_done <= rnd_done | rec;
                  state    <= ST_PRE;
               end else begin
                  retry     <= '0;
                  rnd_done  <= '0;
                  err_acc   <= err_acc | pend_left;
                  round_cnt <= round_cnt + 1'b1;
                  if (round_cnt == LAST_ROUND) begin
                     state  <= ST_FIN;
                     DONE   <= 1'b1;
                     RESULT <= res_nxt;
                     ERR    <= (err_acc | pend_left) & en_q;
                  end else begin
                     state <= ST_PRE;
                  end
               end
            end

            ST_FIN: begin
               BUSY  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               BUSY     <= 1'b0;
               COMP_CLK <= '0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comparator_seq.sv
// Self-checking bench for comparator_seq: a behavioural latch model feeds
// per-attempt rail patterns, and a round/retry/vote reference predicts
// RESULT, ERR, DONE latency and latch-clock pulse counts.
module tb_comparator_seq;

   localparam int N_CH   = 4;
   localparam int N_VOTE = 3;
   localparam int RETRY  = 2;
   localparam int A      = 1 + 2 + 3;   // RESET_CYC + EVAL_CYC + 3
   localparam int N_ATT  = N_VOTE * (RETRY + 1);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [N_CH-1:0] ch_en = '0;
   logic [N_CH-1:0] comp_clk;
   logic [N_CH-1:0] outp = '1;
   logic [N_CH-1:0] outn = '1;
   logic            busy;
   logic            done;
   logic [N_CH-1:0] result;
   logic [N_CH-1:0] err;

   int errors = 0;
   int checks = 0;

   logic [N_CH-1:0] p_tab [N_ATT];
   logic [N_CH-1:0] n_tab [N_ATT];
   logic [N_CH-1:0] en_live = '0;
   logic [N_CH-1:0] prev_cc = '0;
   int att_total = 0;
   int att_base  = 0;
   int bad_rise  = 0;
   int rise_cnt [N_CH];

   comparator_seq dut (
      .CLK      (clk),
      .RST      (rst),
      .START    (start),
      .CH_EN    (ch_en),
      .COMP_CLK (comp_clk),
      .Outp     (outp),
      .Outn     (outn),
      .BUSY     (busy),
      .DONE     (done),
      .RESULT   (result),
      .ERR      (err)
   );

   always #5 clk = ~clk;

   // Latch model: resolves to the table entry of the current attempt when
   // its clock rises, returns to both-high while precharged.
   always @(negedge clk) begin
      int idx;
      for (int i = 0; i < N_CH; i++)
         if (comp_clk[i] && !prev_cc[i]) rise_cnt[i] = rise_cnt[i] + 1;
      if ((comp_clk & ~en_live) != '0) bad_rise = bad_rise + 1;
      if (comp_clk != '0 && prev_cc == '0) begin
         idx = att_total - att_base;
         if (idx > N_ATT - 1) idx = N_ATT - 1;
         outp = p_tab[idx];
         outn = n_tab[idx];
         att_total = att_total + 1;
      end else if (comp_clk == '0 && prev_cc != '0) begin
         outp = '1;
         outn = '1;
      end
      prev_cc = comp_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: each round fires every enabled channel; a channel records on
   // its first valid attempt; up to RETRY extra attempts while any is pending.
   function automatic void model(input logic [N_CH-1:0] en, output logic [N_CH-1:0] res,
                                 output logic [N_CH-1:0] er, output int att);
      int vts [N_CH];
      int vld [N_CH];
      logic [N_CH-1:0] pend;
      logic [N_CH-1:0] p;
      logic [N_CH-1:0] n;
      att = 0;
      er  = '0;
      res = '0;
      for (int i = 0; i < N_CH; i++) begin vts[i] = 0; vld[i] = 0; end
      if (en != '0) begin
         for (int r = 0; r < N_VOTE; r++) begin
            pend = en;
            for (int a = 0; a <= RETRY && pend != '0; a++) begin
               p = p_tab[att];
               n = n_tab[att];
               att++;
               for (int i = 0; i < N_CH; i++)
                  if (pend[i] && (p[i] != n[i])) begin
                     vts[i] += p[i] ? 1 : 0;
                     vld[i] += 1;
                     pend[i] = 1'b0;
                  end
            end
            er |= pend;
         end
         for (int i = 0; i < N_CH; i++) res[i] = en[i] && (2 * vts[i] > vld[i]);
      end
   endfunction

   task automatic fill(input logic [N_CH-1:0] p, input logic [N_CH-1:0] n);
      for (int a = 0; a < N_ATT; a++) begin p_tab[a] = p; n_tab[a] = n; end
   endtask

   task automatic fill_rand(input bit valid_only);
      for (int a = 0; a < N_ATT; a++) begin
         p_tab[a] = N_CH'($urandom);
         n_tab[a] = valid_only ? ~p_tab[a] : N_CH'($urandom);
      end
   endtask

   // One conversion; want_lat < 0 takes the latency from the reference model.
   task automatic run_conv(input logic [N_CH-1:0] en, input string tag, input int want_lat);
      logic [N_CH-1:0] res_e;
      logic [N_CH-1:0] err_e;
      int att, lat, n, bad0;
      int rs0 [N_CH];
      model(en, res_e, err_e, att);
      lat = (want_lat >= 0) ? want_lat : ((en == '0) ? 1 : 1 + att * A);
      rs0 = rise_cnt;
      bad0 = bad_rise;
      att_base = att_total;
      en_live = en;
      ch_en = en;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      check({tag, "_busy"}, 32'(busy), 32'(1));
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
         if (n == 3) ch_en = ~en;
      end
      check({tag, "_lat"}, 32'(n), 32'(lat));
      check({tag, "_result"}, 32'(result), 32'(res_e));
      check({tag, "_err"}, 32'(err), 32'(err_e));
      for (int i = 0; i < N_CH; i++)
         check($sformatf("%s_pulses%0d", tag, i), 32'(rise_cnt[i] - rs0[i]), en[i] ? 32'(att) : 32'(0));
      check({tag, "_stray_clk"}, 32'(bad_rise - bad0), 32'(0));
      @(negedge clk);
      check({tag, "_idle"}, {30'b0, busy, done}, 32'(0));
   endtask

   initial begin
      int n, lat1;
      bit seen;
      logic [N_CH-1:0] res_e, err_e;
      int att;
      for (int i = 0; i < N_CH; i++) rise_cnt[i] = 0;
      fill('1, '1);

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_comp_clk", 32'(comp_clk), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_result", 32'(result), 32'(0));
      check("rst_err", 32'(err), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      // Constant rails on all channels
      fill(4'b1010, 4'b0101);
      run_conv(4'b1111, "const", 19);

      // Channel 0 votes 1,0,1 then 0,1,0
      p_tab[0] = 4'b1011; p_tab[1] = 4'b1010; p_tab[2] = 4'b1011;
      for (int a = 0; a < 3; a++) n_tab[a] = ~p_tab[a];
      run_conv(4'b1111, "vote101", 19);
      p_tab[0] = 4'b1010; p_tab[1] = 4'b1011; p_tab[2] = 4'b1010;
      for (int a = 0; a < 3; a++) n_tab[a] = ~p_tab[a];
      run_conv(4'b1111, "vote010", 19);

      // Channel 2 unresolved on the first attempt only
      fill(4'b0011, 4'b1100);
      p_tab[0] = 4'b0010; n_tab[0] = 4'b1001;
      p_tab[1] = 4'b0110; n_tab[1] = 4'b1001;
      p_tab[2] = 4'b0101; n_tab[2] = 4'b1010;
      p_tab[3] = 4'b0011; n_tab[3] = 4'b1100;
      run_conv(4'b1111, "retry1", 25);
      check("retry1_ch0_no_dbl", 32'(result[0]), 32'(1));

      // Channel 1 always both-high
      fill(4'b0011, 4'b1110);
      run_conv(4'b1111, "stuck", 55);
      check("stuck_err1", 32'(err[1]), 32'(1));
      check("stuck_res1", 32'(result[1]), 32'(0));

      // No channels enabled
      run_conv(4'b0000, "none", 1);

      // Single channel, START held high: back-to-back conversions
      fill_rand(1'b1);
      model(4'b0100, res_e, err_e, att);
      lat1 = 1 + att * A;
      att_base = att_total;
      en_live = 4'b0100;
      ch_en = 4'b0100;
      start = 1'b1;
      n = 0;
      seen = 0;
      while (!done && n < 200) begin @(negedge clk); n++; end
      check("b2b_lat1", 32'(n), 32'(19));
      check("b2b_res", 32'(result), 32'(res_e));
      @(negedge clk);
      n++;
      check("b2b_gap_idle", 32'(busy), 32'(0));
      att_base = att_total;
      while (!done && n < 200) begin @(negedge clk); n++; end
      check("b2b_lat2", 32'(n), 32'(2 * lat1 + 1));
      check("b2b_res3", 32'(result[3]), 32'(0));
      check("b2b_stray", 32'(bad_rise), 32'(0));
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("b2b_stop", 32'(busy), 32'(0));

      // Mid-conversion reset
      fill(4'b1111, 4'b0000);
      run_conv(4'b1111, "allone", 19);
      fill_rand(1'b1);
      att_base = att_total;
      en_live = 4'b1111;
      ch_en = 4'b1111;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (n < 8) begin @(negedge clk); n++; end
      check("rstmid_pre_cc", 32'(comp_clk), 32'(4'b1111));
      rst = 1'b1;
      #1;
      check("rstmid_comp_clk", 32'(comp_clk), 32'(0));
      check("rstmid_busy", 32'(busy), 32'(0));
      check("rstmid_result", 32'(result), 32'(0));
      check("rstmid_err", 32'(err), 32'(0));
      check("rstmid_done", 32'(done), 32'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (30) begin @(negedge clk); if (done || busy) seen = 1; end
      check("rstmid_quiet", 32'(seen), 32'(0));
      fill_rand(1'b1);
      run_conv(4'b1111, "post_rst", 19);

      // Randomised rails and enables
      for (int t = 0; t < 6; t++) begin
         fill_rand(1'b0);
         run_conv(N_CH'($urandom), $sformatf("rand%0d", t), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
